// File: rtl/sramc_drain_pkg.sv
// Shared types and constants for the SRAMC bank-0 drain sequencer.
// Optional build macro used by the top: SRAMC_DRAIN_STALL_CNT_EN.
package sramc_drain_pkg;

  localparam int LINE_W         = 128;
  localparam int LINES_PER_CH   = 64;
  localparam int WORDS_PER_LINE = 4;
  localparam int MAX_CHS        = 8;
  localparam int LINE_IDX_W     = $clog2(LINES_PER_CH);
  localparam int CH_IDX_W       = $clog2(MAX_CHS);

  typedef logic [CH_IDX_W-1:0]   ch_idx_t;
  typedef logic [LINE_IDX_W-1:0] line_idx_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    ch_idx_t           ch;
    logic              last;
  } beat_t;

  // Requested channel count limited to what one run can address.
  function automatic logic [3:0] clamp_chs(input logic [3:0] n);
    return (n > 4'(MAX_CHS)) ? 4'(MAX_CHS) : n;
  endfunction

endpackage

// File: rtl/sramc_drain_fifo.sv
// Two-entry skid FIFO holding tagged read-out beats ahead of the stream port.
module sramc_drain_fifo
  import sramc_drain_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head_beat,
  output logic [1:0] occ
);

  beat_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] occ_q;

  // Storage, pointers and occupancy; storage is cleared so the stream outputs reset to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_beat = mem_q[rd_ptr_q];
  assign occ       = occ_q;

  // The issue credit makes a push into a full FIFO without a pop impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ_q == 2'd2));

endmodule

// File: rtl/sramc_drain_seq.sv
// Read-out sequencer for SRAMC bank 0: walks channels of 64 lines and streams
// each line as one valid/ready beat tagged with channel and last-line flags.
// Build macro SRAMC_DRAIN_STALL_CNT_EN enables the backpressure cycle counter.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start_i; read port and stream quiet
//   ST_RUN   | issuing one read per cycle while FIFO credit remains
//   ST_FLUSH | all reads issued; waiting for in-flight data and FIFO to drain
//   ST_DONE  | one-cycle completion pulse, then back to idle
module sramc_drain_seq
  import sramc_drain_pkg::*;
#(
  parameter int DATA_W = LINE_W,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        num_chs_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sram_req_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic [2:0]        m_ch_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic [31:0]       stall_cnt_o
);

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  ch_idx_t           last_ch_q;
  ch_idx_t           ch_q;
  line_idx_t         line_q;
  logic              inflight_q;
  ch_idx_t           tag_ch_q;
  logic              tag_last_q;

  logic [3:0]        num_clamped;
  logic              start_acc;
  logic              pop;
  logic              issue;
  logic              line_end;
  logic              final_issue;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        occ;
  beat_t             head;
  beat_t             push_beat;

  assign num_clamped = clamp_chs(num_chs_i);
  assign start_acc   = (state_q == ST_IDLE) && start_i;
  assign m_valid_o   = (occ != 2'd0);
  assign pop         = m_valid_o && m_ready_i;
  // Two slots shared between FIFO entries and the read in flight; a pop frees one this cycle.
  assign issue       = (state_q == ST_RUN) &&
                       (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign line_end    = (line_q == line_idx_t'(LINES_PER_CH - 1));
  assign final_issue = issue && line_end && (ch_q == last_ch_q);
  // ch*64 + line is just the concatenation; the sum wraps within the address width.
  assign rd_addr     = base_q + ADDR_W'({ch_q, line_q});

  // Sequencer state and channel/line walk.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      last_ch_q <= '0;
      ch_q      <= '0;
      line_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            base_q    <= base_addr_i;
            last_ch_q <= ch_idx_t'(num_clamped - 4'd1);
            ch_q      <= '0;
            line_q    <= '0;
            state_q   <= (num_clamped == 4'd0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            line_q <= line_q + line_idx_t'(1);
            if (line_end) begin
              ch_q <= ch_q + ch_idx_t'(1);
            end
            if (final_issue) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (!inflight_q && (occ == 2'd0)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tags travel alongside the one-cycle SRAM read so returning data is labelled correctly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      tag_ch_q   <= '0;
      tag_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_ch_q   <= ch_q;
        tag_last_q <= line_end;
      end
    end
  end

  // Assemble the returning line and its tags into a FIFO entry.
  always_comb begin
    push_beat      = '0;
    push_beat.data = sram_rdata_i;
    push_beat.ch   = tag_ch_q;
    push_beat.last = tag_last_q;
  end

  sramc_drain_fifo u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (pop),
    .head_beat (head),
    .occ       (occ)
  );

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign sram_req_o  = issue;
  assign sram_addr_o = issue ? rd_addr : '0;
  assign m_data_o    = head.data;
  assign m_ch_o      = head.ch;
  assign m_last_o    = m_valid_o && head.last;

`ifdef SRAMC_DRAIN_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Backpressured cycles since the last accepted start; saturates, holds after the run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (start_acc) begin
      stall_cnt_q <= '0;
    end else if (m_valid_o && !m_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sramc_drain_seq.sv
// Directed bench for sramc_drain_seq: SRAM model with preloaded lines, a
// negedge stream monitor, and one task per scenario with inline checks.
module tb_sramc_drain_seq;
  import sramc_drain_pkg::*;

  localparam int AW = 10;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    num_chs = 4'd0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, sram_req;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [2:0]    m_ch;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic [31:0]   stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sramc_drain_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_chs_i(num_chs),
    .base_addr_i(base_addr), .busy_o(busy), .done_o(done),
    .sram_req_o(sram_req), .sram_addr_o(sram_addr), .sram_rdata_i(sram_rdata),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_ch_o(m_ch), .m_last_o(m_last),
    .m_ready_i(m_ready), .stall_cnt_o(stall_cnt)
  );

  function automatic logic [DW-1:0] line_val(input int a);
    logic [31:0] w;
    w = 32'(a);
    return {w ^ 32'hA5A5_0000, ~w, w * 32'd3 + 32'd7, w ^ 32'h0F0F_F0F0};
  endfunction

  logic [DW-1:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = line_val(i);

  always @(posedge clk) if (sram_req) sram_rdata <= mem[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  end

  int            e0 = 0;
  beat_t         beats [$];
  logic [AW-1:0] req_addrs [$];
  int first_req_rel, first_valid_rel, last_beat_rel, done_rel, done_cnt;
  int issued, accepted, over_cnt, hold_viol, stall_seen, valid_cnt;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic clear_mon();
    beats.delete();
    req_addrs.delete();
    first_req_rel = -1; first_valid_rel = -1; last_beat_rel = -1;
    done_rel = -1; done_cnt = 0; issued = 0; accepted = 0;
    over_cnt = 0; hold_viol = 0; stall_seen = 0; valid_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (sram_req) begin
        req_addrs.push_back(sram_addr);
        issued++;
        if (first_req_rel < 0) first_req_rel = cyc - e0;
      end
      if (m_valid) begin
        valid_cnt++;
        if (first_valid_rel < 0) first_valid_rel = cyc - e0;
      end
      if (prev_stall && (!m_valid || m_data !== prev_beat.data ||
                         m_ch !== prev_beat.ch || m_last !== prev_beat.last))
        hold_viol++;
      if (m_valid && m_ready) begin
        beats.push_back('{data: m_data, ch: m_ch, last: m_last});
        accepted++;
        last_beat_rel = cyc - e0;
      end
      if (issued - accepted > 2) over_cnt++;
      if (m_valid && !m_ready) stall_seen++;
      prev_stall = m_valid && !m_ready;
      prev_beat  = '{data: m_data, ch: m_ch, last: m_last};
      if (done) begin
        done_cnt++;
        done_rel = cyc - e0;
      end
    end
  end

  function automatic int bad_beats(input int base, input int n);
    int bad;
    int a;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= beats.size()) begin
        bad++;
      end else begin
        a = (base + i) % 1024;
        if (beats[i].data !== line_val(a) || beats[i].ch !== 3'(i / 64) ||
            beats[i].last !== ((i % 64) == 63))
          bad++;
      end
    end
    return bad;
  endfunction

  function automatic int bad_addrs(input int base, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= req_addrs.size()) bad++;
      else if (req_addrs[i] !== AW'((base + i) % 1024)) bad++;
    end
    return bad;
  endfunction

  task automatic start_run(input logic [3:0] n, input logic [AW-1:0] base);
    @(posedge clk); #1;
    clear_mon();
    start = 1'b1; num_chs = n; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc - 1;
  endtask

  task automatic wait_done(input int max_cyc, output bit to);
    to = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
    vectors++; if (sram_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", sram_req); end
    vectors++; if (sram_addr !== '0) begin miscompares++; $display("FAIL rst_addr got %h want 0", sram_addr); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", m_valid); end
    vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL rst_last got %b want 0", m_last); end
    vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL rst_data got %h want 0", m_data); end
    vectors++; if (m_ch !== 3'd0) begin miscompares++; $display("FAIL rst_ch got %0d want 0", m_ch); end
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_one_ch();
    bit to;
    start_run(4'd1, 10'h000);
    wait_done(300, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL one_timeout got %b want 0", to); end
    vectors++; if (beats.size() != 64) begin miscompares++; $display("FAIL one_beats got %0d want 64", beats.size()); end
    vectors++; if (bad_beats(0, 64) != 0) begin miscompares++; $display("FAIL one_beat_data got %0d bad want 0", bad_beats(0, 64)); end
    vectors++; if (issued != 64) begin miscompares++; $display("FAIL one_reqs got %0d want 64", issued); end
    vectors++; if (bad_addrs(0, 64) != 0) begin miscompares++; $display("FAIL one_addrs got %0d bad want 0", bad_addrs(0, 64)); end
    vectors++; if (first_req_rel != 1) begin miscompares++; $display("FAIL one_first_req got %0d want 1", first_req_rel); end
    vectors++; if (first_valid_rel != 3) begin miscompares++; $display("FAIL one_first_valid got %0d want 3", first_valid_rel); end
    vectors++; if (last_beat_rel != 66) begin miscompares++; $display("FAIL one_last_beat got %0d want 66", last_beat_rel); end
    vectors++; if (done_rel != 68) begin miscompares++; $display("FAIL one_done_cycle got %0d want 68", done_rel); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL one_done_pulses got %0d want 1", done_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL one_busy_after got %b want 0", busy); end
  endtask

  task automatic test_eight_ch();
    bit to;
    start_run(4'd8, 10'h000);
    wait_done(1500, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL eight_timeout got %b want 0", to); end
    vectors++; if (beats.size() != 512) begin miscompares++; $display("FAIL eight_beats got %0d want 512", beats.size()); end
    vectors++; if (bad_beats(0, 512) != 0) begin miscompares++; $display("FAIL eight_beat_data got %0d bad want 0", bad_beats(0, 512)); end
    vectors++; if (done_rel != 516) begin miscompares++; $display("FAIL eight_done_cycle got %0d want 516", done_rel); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [31:0] exp_stall;
    ready_mode = 1;
    start_run(4'd2, 10'h100);
    wait_done(3000, to);
    ready_mode = 0;
`ifdef SRAMC_DRAIN_STALL_CNT_EN
    exp_stall = 32'(stall_seen);
`else
    exp_stall = 32'd0;
`endif
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL bp_timeout got %b want 0", to); end
    vectors++; if (beats.size() != 128) begin miscompares++; $display("FAIL bp_beats got %0d want 128", beats.size()); end
    vectors++; if (bad_beats(256, 128) != 0) begin miscompares++; $display("FAIL bp_beat_data got %0d bad want 0", bad_beats(256, 128)); end
    vectors++; if (hold_viol != 0) begin miscompares++; $display("FAIL bp_hold got %0d violations want 0", hold_viol); end
    vectors++; if (over_cnt != 0) begin miscompares++; $display("FAIL bp_outstanding got %0d cycles over 2 want 0", over_cnt); end
    vectors++; if (stall_cnt !== exp_stall) begin miscompares++; $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    bit to;
    start_run(4'd1, 10'h3F0);
    wait_done(300, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL wrap_timeout got %b want 0", to); end
    vectors++; if (bad_addrs(10'h3F0, 64) != 0) begin miscompares++; $display("FAIL wrap_addrs got %0d bad want 0", bad_addrs(10'h3F0, 64)); end
    if (req_addrs.size() > 16) begin
      vectors++; if (req_addrs[16] !== 10'h000) begin miscompares++; $display("FAIL wrap_addr16 got %h want 000", req_addrs[16]); end
    end
    vectors++; if (bad_beats(10'h3F0, 64) != 0) begin miscompares++; $display("FAIL wrap_beat_data got %0d bad want 0", bad_beats(10'h3F0, 64)); end
  endtask

  task automatic test_zero();
    bit to;
    start_run(4'd0, 10'h005);
    wait_done(20, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL zero_timeout got %b want 0", to); end
    vectors++; if (done_rel != 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d want 1", done_rel); end
    vectors++; if (issued != 0) begin miscompares++; $display("FAIL zero_reqs got %0d want 0", issued); end
    vectors++; if (beats.size() != 0) begin miscompares++; $display("FAIL zero_beats got %0d want 0", beats.size()); end
  endtask

  task automatic test_start_ignored();
    bit to;
    start_run(4'd2, 10'h000);
    repeat (40) @(posedge clk);
    #1;
    start = 1'b1; num_chs = 4'd5; base_addr = 10'h200;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1000, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL ign_timeout got %b want 0", to); end
    vectors++; if (beats.size() != 128) begin miscompares++; $display("FAIL ign_beats got %0d want 128", beats.size()); end
    vectors++; if (bad_beats(0, 128) != 0) begin miscompares++; $display("FAIL ign_beat_data got %0d bad want 0", bad_beats(0, 128)); end
    vectors++; if (done_rel != 132) begin miscompares++; $display("FAIL ign_done_cycle got %0d want 132", done_rel); end
  endtask

  task automatic test_clamp();
    bit to;
    start_run(4'd12, 10'h040);
    wait_done(1500, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL clamp_timeout got %b want 0", to); end
    vectors++; if (beats.size() != 512) begin miscompares++; $display("FAIL clamp_beats got %0d want 512", beats.size()); end
    vectors++; if (bad_beats(10'h040, 512) != 0) begin miscompares++; $display("FAIL clamp_beat_data got %0d bad want 0", bad_beats(10'h040, 512)); end
    vectors++; if (done_rel != 516) begin miscompares++; $display("FAIL clamp_done_cycle got %0d want 516", done_rel); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit got10;
    start_run(4'd2, 10'h000);
    got10 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (beats.size() >= 10) begin
        got10 = 1'b1;
        break;
      end
    end
    vectors++; if (got10 !== 1'b1) begin miscompares++; $display("FAIL mid_reach10 got %b want 1", got10); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done got %b want 0", done); end
    vectors++; if (sram_req !== 1'b0) begin miscompares++; $display("FAIL mid_req got %b want 0", sram_req); end
    vectors++; if (sram_addr !== '0) begin miscompares++; $display("FAIL mid_addr got %h want 0", sram_addr); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", m_valid); end
    vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL mid_last got %b want 0", m_last); end
    vectors++; if (m_data !== '0) begin miscompares++; $display("FAIL mid_data got %h want 0", m_data); end
    vectors++; if (m_ch !== 3'd0) begin miscompares++; $display("FAIL mid_ch got %0d want 0", m_ch); end
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL mid_stall got %0d want 0", stall_cnt); end
    clear_mon();
    repeat (3) @(negedge clk);
    vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL mid_late_data got %0d valid cycles want 0", valid_cnt); end
    vectors++; if (issued != 0) begin miscompares++; $display("FAIL mid_idle_reqs got %0d want 0", issued); end
    start_run(4'd1, 10'h000);
    wait_done(300, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL mid_rerun_timeout got %b want 0", to); end
    vectors++; if (beats.size() != 64) begin miscompares++; $display("FAIL mid_rerun_beats got %0d want 64", beats.size()); end
    vectors++; if (bad_beats(0, 64) != 0) begin miscompares++; $display("FAIL mid_rerun_data got %0d bad want 0", bad_beats(0, 64)); end
    vectors++; if (done_rel != 68) begin miscompares++; $display("FAIL mid_rerun_done got %0d want 68", done_rel); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_one_ch();
    test_eight_ch();
    test_backpressure();
    test_wrap();
    test_zero();
    test_start_ignored();
    test_clamp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
